// File: rtl/abro_stim_generator.sv
// Stimulus generator for an ABRO detector: emits rounds of A,B,A,B pulses separated by
// programmable gaps and counts rounds in which the detector's O output was not seen.
module abro_stim_generator #(
    parameter int GAP_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [GAP_W-1:0] gap,
    input  logic [CNT_W-1:0] rounds,
    input  logic             o_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] rounds_sent
);

    typedef enum logic [3:0] {
        IDLE, A1, G1, B1, G2, A2, G3, B2, G4, DONE
    } state_t;

    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [GAP_W-1:0] gap_lat_reg;
    logic [CNT_W-1:0] rounds_lat_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             after_a2_reg;
    logic [CNT_W-1:0] err_count_reg;
    logic [CNT_W-1:0] rounds_sent_reg;
    logic             a_reg, b_reg, busy_reg, done_reg;
    logic             a_next, b_next, busy_next, done_next;

    logic gap_zero, gap_last, last_round, round_end, in_gap_next;

    assign gap_zero   = (gap_lat_reg == '0);
    assign gap_last   = (gap_cnt_reg == '0);
    // Extra bit keeps the +1 from wrapping when rounds_sent is all-ones.
    assign last_round = ({1'b0, rounds_sent_reg} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, rounds_lat_reg};
    assign round_end  = ((state_reg == B2) && gap_zero) || ((state_reg == G4) && gap_last);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: if (start) state_next = (rounds == '0) ? DONE : A1;
            A1:   state_next = gap_zero ? B1 : G1;
            G1:   if (gap_last) state_next = B1;
            B1:   state_next = gap_zero ? A2 : G2;
            G2:   if (gap_last) state_next = A2;
            A2:   state_next = gap_zero ? B2 : G3;
            G3:   if (gap_last) state_next = B2;
            B2:   if (gap_zero) state_next = last_round ? DONE : A1;
                  else          state_next = G4;
            G4:   if (gap_last) state_next = last_round ? DONE : A1;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_reg.
    always_comb begin
        a_next      = (state_next == A1) || (state_next == A2);
        b_next      = (state_next == B1) || (state_next == B2);
        busy_next   = (state_next != IDLE) && (state_next != DONE);
        done_next   = (state_next == DONE);
        in_gap_next = (state_next == G1) || (state_next == G2) ||
                      (state_next == G3) || (state_next == G4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            gap_lat_reg     <= '0;
            rounds_lat_reg  <= '0;
            gap_cnt_reg     <= '0;
            after_a2_reg    <= 1'b0;
            err_count_reg   <= '0;
            rounds_sent_reg <= '0;
            a_reg           <= 1'b0;
            b_reg           <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg    <= state_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            after_a2_reg <= (state_reg == A2);

            if (in_gap_next && (state_next != state_reg))
                gap_cnt_reg <= gap_lat_reg - GAP_ONE;
            else if (!gap_last)
                gap_cnt_reg <= gap_cnt_reg - GAP_ONE;

            if ((state_reg == IDLE) && start) begin
                gap_lat_reg     <= gap;
                rounds_lat_reg  <= rounds;
                err_count_reg   <= '0;
                rounds_sent_reg <= '0;
            end else begin
                if (after_a2_reg && !o_in && !(&err_count_reg))
                    err_count_reg <= err_count_reg + CNT_ONE;
                if (round_end && !(&rounds_sent_reg))
                    rounds_sent_reg <= rounds_sent_reg + CNT_ONE;
            end
        end
    end

    assign a_out       = a_reg;
    assign b_out       = b_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err_count   = err_count_reg;
    assign rounds_sent = rounds_sent_reg;

endmodule
